// File: rtl/div11_seq_ctrl.sv
// Sequential divide-by-11 controller: consumes a WIDTH-bit dividend MSB-first,
// DIGIT_BITS per cycle, with valid/ready handshakes on input and output.
module div11_seq_ctrl #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DIGIT_BITS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_dividend,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quot,
    output logic [3:0]       out_rem,
    output logic             busy
);

    localparam int unsigned STEPS = WIDTH / DIGIT_BITS;
    localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int unsigned T_W   = 4 + DIGIT_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    logic [WIDTH-1:0]      shreg;
    logic [WIDTH-1:0]      quot;
    logic [3:0]            rem;
    logic [CNT_W-1:0]      cnt;

    logic [T_W-1:0]        step_t;
    logic [T_W-1:0]        step_r;
    logic [DIGIT_BITS-1:0] step_q;
    logic [WIDTH-1:0]      quot_next;

    // One radix-2^DIGIT_BITS step: restoring division of t = rem*2^D + d by 11.
    // rem <= 10 keeps q below 2^D, so D compare/subtract stages suffice.
    always_comb begin
        step_t = {rem, shreg[WIDTH-1 -: DIGIT_BITS]};
        step_r = step_t;
        step_q = '0;
        for (int k = DIGIT_BITS - 1; k >= 0; k--) begin
            if (step_r >= (T_W'(11) << k)) begin
                step_r    = step_r - (T_W'(11) << k);
                step_q[k] = 1'b1;
            end
        end
        quot_next = {quot[WIDTH-DIGIT_BITS-1:0], step_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_quot  <= '0;
            out_rem   <= '0;
            rem       <= '0;
            shreg     <= '0;
            quot      <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        shreg    <= in_dividend;
                        rem      <= '0;
                        quot     <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    rem   <= 4'(step_r);
                    quot  <= quot_next;
                    shreg <= {shreg[WIDTH-DIGIT_BITS-1:0], DIGIT_BITS'(0)};
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(STEPS - 1)) begin
                        out_quot  <= quot_next;
                        out_rem   <= 4'(step_r);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // Input stays blocked through the output handshake cycle.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    rem_in_range: assert property (@(posedge clk) disable iff (rst) rem <= 4'd10);

endmodule
